// File: rtl/rsa_cmd_parser_if.sv
// Signal bundle between rsa_cmd_parser, the UART receiver and the RSA core.
// The master modport is the parser's view. The slave modport is the environment's view.
interface rsa_cmd_parser_if #(
    parameter int WIDTH_DEG   = 8,
    parameter int WIDTH_N     = 8,
    parameter int WIDTH_MSG_I = 8
);
    // rx_valid and rsa_finish are single-cycle strobes with no back-pressure.
    // A byte is consumed in the cycle its strobe is high. A byte arriving while
    // the parser is busy with the RSA core is dropped and flagged on err.
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   rsa_finish;
    logic                   start_o;
    logic                   eORd;
    logic [WIDTH_MSG_I-1:0] msg_o;
    logic [WIDTH_DEG-1:0]   e_o;
    logic [WIDTH_DEG-1:0]   d_o;
    logic [WIDTH_N-1:0]     n_o;
    logic                   busy;
    logic                   err;
    logic [1:0]             state_dbg;

    modport master (
        input  rx_valid, rx_data, rsa_finish,
        output start_o, eORd, msg_o, e_o, d_o, n_o, busy, err, state_dbg
    );

    modport slave (
        output rx_valid, rx_data, rsa_finish,
        input  start_o, eORd, msg_o, e_o, d_o, n_o, busy, err, state_dbg
    );
endinterface

// File: rtl/rsa_cmd_parser.sv
// UART byte-stream command parser feeding the RSA core (E/D message frames, K key-load frames).
// Defining RSA_CMD_CHKSUM_EN adds a trailing XOR checksum byte to every frame.
module rsa_cmd_parser #(
    parameter int WIDTH_DEG   = 8,
    parameter int WIDTH_N     = 8,
    parameter int WIDTH_MSG_I = 8,
    parameter int E_RST       = 7,
    parameter int D_RST       = 13,
    parameter int N_RST       = 33,
    parameter int TIMEOUT_CYC = 250000
) (
    input logic              clk,
    input logic              reset,
    rsa_cmd_parser_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, WAIT_FIN = 2'd2} state_t;

    localparam logic [7:0] OP_E = 8'h45;
    localparam logic [7:0] OP_D = 8'h44;
    localparam logic [7:0] OP_K = 8'h4B;

    localparam int B_MSG = (WIDTH_MSG_I + 7) / 8;
    localparam int B_DEG = (WIDTH_DEG + 7) / 8;
    localparam int B_N   = (WIDTH_N + 7) / 8;
    localparam int B_KEY = 2 * B_DEG + B_N;
    localparam int B_MAX = (B_KEY > B_MSG) ? B_KEY : B_MSG;
`ifdef RSA_CMD_CHKSUM_EN
    localparam int B_CHK = 1;
    localparam int HW    = 8 * B_MAX;
`else
    localparam int B_CHK = 0;
    // The final payload byte is taken straight from rx_data, so the shadow holds one byte less.
    localparam int HW    = 8 * (B_MAX - 1);
`endif
    localparam int CW = $clog2(B_MAX + B_CHK + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t                 state, state_n;
    logic                   op_key, op_enc;
    logic [CW-1:0]          byte_cnt;
    logic [CW-1:0]          frame_len;
    logic [HW-1:0]          shadow;
    logic [8*B_MAX-1:0]     frame_data;
    logic [TW-1:0]          tmo_cnt;
    logic                   last_byte, tmo_hit, chk_ok, shift_en;
    logic                   take_op, take_byte, done_msg, done_key, err_n;
    logic                   start_q, eord_q, err_q;
    logic [WIDTH_MSG_I-1:0] msg_q;
    logic [WIDTH_DEG-1:0]   e_q, d_q;
    logic [WIDTH_N-1:0]     n_q;

    assign frame_len = op_key ? CW'(B_KEY + B_CHK) : CW'(B_MSG + B_CHK);
    assign last_byte = (byte_cnt == frame_len - CW'(1));
    assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

`ifdef RSA_CMD_CHKSUM_EN
    logic [7:0] chk_acc;
    assign chk_ok     = (bus.rx_data == chk_acc);
    assign shift_en   = take_byte && !last_byte;
    assign frame_data = shadow;
`else
    assign chk_ok     = 1'b1;
    assign shift_en   = take_byte;
    assign frame_data = {shadow, bus.rx_data};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        take_op   = 1'b0;
        take_byte = 1'b0;
        done_msg  = 1'b0;
        done_key  = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == OP_E || bus.rx_data == OP_D || bus.rx_data == OP_K) begin
                        take_op = 1'b1;
                        state_n = PAYLOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    take_byte = 1'b1;
                    if (last_byte) begin
                        if (!chk_ok) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else if (op_key) begin
                            done_key = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            done_msg = 1'b1;
                            state_n  = WAIT_FIN;
                        end
                    end
                end else if (tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_FIN: begin
                if (bus.rx_valid)   err_n   = 1'b1;
                if (bus.rsa_finish) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_key   <= 1'b0;
            op_enc   <= 1'b0;
            byte_cnt <= '0;
            shadow   <= '0;
            tmo_cnt  <= '0;
            start_q  <= 1'b0;
            eord_q   <= 1'b1;
            err_q    <= 1'b0;
            msg_q    <= '0;
            e_q      <= WIDTH_DEG'(E_RST);
            d_q      <= WIDTH_DEG'(D_RST);
            n_q      <= WIDTH_N'(N_RST);
        end else begin
            err_q   <= err_n;
            start_q <= done_msg;
            if (take_op) begin
                op_key   <= (bus.rx_data == OP_K);
                op_enc   <= (bus.rx_data == OP_E);
                byte_cnt <= '0;
            end
            if (take_byte) byte_cnt <= byte_cnt + CW'(1);
            if (shift_en)  shadow   <= {shadow[HW-9:0], bus.rx_data};
            // Idle gap counter only advances while a frame is open.
            if (state != PAYLOAD || take_byte) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + TW'(1);
            if (done_msg) begin
                msg_q  <= frame_data[WIDTH_MSG_I-1:0];
                eord_q <= op_enc;
            end
            if (done_key) begin
                n_q <= frame_data[WIDTH_N-1:0];
                d_q <= frame_data[8*B_N +: WIDTH_DEG];
                e_q <= frame_data[8*(B_N+B_DEG) +: WIDTH_DEG];
            end
        end
    end

`ifdef RSA_CMD_CHKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          chk_acc <= '0;
        else if (take_op)   chk_acc <= bus.rx_data;
        else if (take_byte) chk_acc <= chk_acc ^ bus.rx_data;
    end
`endif

    assign bus.start_o   = start_q;
    assign bus.eORd      = eord_q;
    assign bus.msg_o     = msg_q;
    assign bus.e_o       = e_q;
    assign bus.d_o       = d_q;
    assign bus.n_o       = n_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_rsa_cmd_parser.sv
// Directed bench for rsa_cmd_parser: a frame vector table plus hand-written corner sequences.
// Define RSA_CMD_CHKSUM_EN on both files to exercise the checksum build.
module tb_rsa_cmd_parser;
    localparam int TMO = 20;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    logic [7:0] exp_q[$];

    rsa_cmd_parser_if #(.WIDTH_DEG(8), .WIDTH_N(8), .WIDTH_MSG_I(8)) bus ();

    rsa_cmd_parser #(
        .WIDTH_DEG(8), .WIDTH_N(8), .WIDTH_MSG_I(8),
        .E_RST(7), .D_RST(13), .N_RST(33), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] pl;
        logic [1:0]  nb;
        logic        exp_start;
        logic        exp_eord;
        logic [7:0]  exp_msg;
        logic [7:0]  exp_e;
        logic [7:0]  exp_d;
        logic [7:0]  exp_n;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [23:0] pl, input int nb);
        logic [7:0] cs;
        logic [7:0] b;
        cs = op;
        send_byte(op);
        for (int i = 0; i < nb; i++) begin
            b  = pl[23-8*i -: 8];
            cs = cs ^ b;
            send_byte(b);
        end
`ifdef RSA_CMD_CHKSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic pulse_finish();
        bus.rsa_finish = 1'b1;
        @(negedge clk);
        bus.rsa_finish = 1'b0;
    endtask

    task automatic check_keys(input string tag, input logic [7:0] e, input logic [7:0] d, input logic [7:0] n);
        check({tag, "_e"}, bus.e_o, e);
        check({tag, "_d"}, bus.d_o, d);
        check({tag, "_n"}, bus.n_o, n);
    endtask

    // ---------------- scoreboard: every start pulse must carry the queued message ----------------
    always @(negedge clk) begin
        if (!reset && bus.start_o) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_start", 32'd1, 32'd0);
            end else begin
                check("sb_msg", bus.msg_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int first_err;
        int err_cnt;
        int start_cnt;

        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{8'h45, 24'h050000,    2'd1, 1'b1, 1'b1, 8'h05, 8'h07, 8'h0D, 8'h21};
        vecs[1] = '{8'h44, 24'h0E0000,    2'd1, 1'b1, 1'b0, 8'h0E, 8'h07, 8'h0D, 8'h21};
        vecs[2] = '{8'h4B, 24'h030721,    2'd3, 1'b0, 1'b0, 8'h0E, 8'h03, 8'h07, 8'h21};
        vecs[3] = '{8'h45, 24'hFF0000,    2'd1, 1'b1, 1'b1, 8'hFF, 8'h03, 8'h07, 8'h21};
        vecs[4] = '{8'h44, 24'h450000,    2'd1, 1'b1, 1'b0, 8'h45, 8'h03, 8'h07, 8'h21};
        vecs[5] = '{8'h4B, 24'h4B4445,    2'd3, 1'b0, 1'b0, 8'h45, 8'h4B, 8'h44, 8'h45};
        vecs[6] = '{8'h45, 24'h4B0000,    2'd1, 1'b1, 1'b1, 8'h4B, 8'h4B, 8'h44, 8'h45};

        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rsa_finish = 1'b0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_start", bus.start_o, 1'b0);
        check("rst_eord",  bus.eORd, 1'b1);
        check("rst_msg",   bus.msg_o, 8'h00);
        check("rst_err",   bus.err, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        check_keys("rst", 8'd7, 8'd13, 8'd33);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_start) exp_q.push_back(vecs[i].exp_msg);
            send_frame(vecs[i].op, vecs[i].pl, int'(vecs[i].nb));
            check($sformatf("v%0d_start", i), bus.start_o, vecs[i].exp_start);
            check($sformatf("v%0d_busy", i),  bus.busy, vecs[i].exp_start);
            check($sformatf("v%0d_eord", i),  bus.eORd, vecs[i].exp_eord);
            check($sformatf("v%0d_msg", i),   bus.msg_o, vecs[i].exp_msg);
            check_keys($sformatf("v%0d", i), vecs[i].exp_e, vecs[i].exp_d, vecs[i].exp_n);
            check($sformatf("v%0d_err", i),   bus.err, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d_start_1cyc", i), bus.start_o, 1'b0);
            if (vecs[i].exp_start) begin
                repeat (2) @(negedge clk);
                check($sformatf("v%0d_wait_busy", i), bus.busy, 1'b1);
                check($sformatf("v%0d_wait_msg", i),  bus.msg_o, vecs[i].exp_msg);
                pulse_finish();
                check($sformatf("v%0d_fin_busy", i), bus.busy, 1'b0);
            end
        end

        // Reset restores the keys and operands
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_keys("rst2", 8'd7, 8'd13, 8'd33);
        check("rst2_msg",  bus.msg_o, 8'h00);
        check("rst2_eord", bus.eORd, 1'b1);

        // Reset mid-frame returns to IDLE
        send_byte(8'h4B);
        send_byte(8'h01);
        check("midframe_busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midframe_rst_busy", bus.busy, 1'b0);
        check_keys("midframe", 8'd7, 8'd13, 8'd33);

        // Inter-byte timeout: exactly one err pulse, TMO cycles after the opcode
        send_byte(8'h45);
        first_err = 0;
        err_cnt   = 0;
        for (int c = 1; c <= TMO + 8; c++) begin
            @(negedge clk);
            if (bus.err) begin
                err_cnt++;
                if (first_err == 0) first_err = c;
            end
        end
        check("tmo_err_cycle", first_err, TMO);
        check("tmo_err_count", err_cnt, 1);
        check("tmo_busy",      bus.busy, 1'b0);
        check("tmo_msg",       bus.msg_o, 8'h00);
        exp_q.push_back(8'h02);
        send_frame(8'h45, 24'h020000, 1);
        check("post_tmo_start", bus.start_o, 1'b1);
        check("post_tmo_msg",   bus.msg_o, 8'h02);
        pulse_finish();

        // A gap shorter than the timeout keeps the frame alive
        send_byte(8'h44);
        repeat (TMO - 5) @(negedge clk);
        check("gap_busy", bus.busy, 1'b1);
        exp_q.push_back(8'h09);
`ifdef RSA_CMD_CHKSUM_EN
        send_byte(8'h09);
        send_byte(8'h44 ^ 8'h09);
`else
        send_byte(8'h09);
`endif
        check("gap_start", bus.start_o, 1'b1);
        check("gap_eord",  bus.eORd, 1'b0);
        pulse_finish();

        // Unknown opcode
        send_byte(8'h7A);
        check("unk_err",  bus.err, 1'b1);
        check("unk_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("unk_err_1cyc", bus.err, 1'b0);

        // Byte during WAIT_FIN coincident with rsa_finish
        exp_q.push_back(8'h04);
        send_frame(8'h45, 24'h040000, 1);
        bus.rx_valid   = 1'b1;
        bus.rx_data    = 8'h11;
        bus.rsa_finish = 1'b1;
        @(negedge clk);
        bus.rx_valid   = 1'b0;
        bus.rsa_finish = 1'b0;
        check("coinc_err",   bus.err, 1'b1);
        check("coinc_busy",  bus.busy, 1'b0);
        check("coinc_msg",   bus.msg_o, 8'h04);
        check("coinc_start", bus.start_o, 1'b0);

        // rsa_finish outside WAIT_FIN is ignored
        pulse_finish();
        check("stray_fin_busy", bus.busy, 1'b0);
        check("stray_fin_err",  bus.err, 1'b0);

        // K frame bytes during WAIT_FIN are dropped, keys stay put
        exp_q.push_back(8'h06);
        send_frame(8'h44, 24'h060000, 1);
        start_cnt = 0;
        send_byte(8'h4B);
        check("wf_k_err", bus.err, 1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("wf_busy", bus.busy, 1'b1);
        check_keys("wf", 8'd7, 8'd13, 8'd33);
        pulse_finish();
        check("wf_fin_busy", bus.busy, 1'b0);
        check_keys("wf_after", 8'd7, 8'd13, 8'd33);
        check("wf_msg", bus.msg_o, 8'h06);

`ifdef RSA_CMD_CHKSUM_EN
        // Checksum good and bad
        exp_q.push_back(8'h05);
        send_byte(8'h45);
        send_byte(8'h05);
        send_byte(8'h40);
        check("cs_ok_start", bus.start_o, 1'b1);
        check("cs_ok_err",   bus.err, 1'b0);
        pulse_finish();
        send_byte(8'h45);
        send_byte(8'h05);
        send_byte(8'h41);
        check("cs_bad_err",   bus.err, 1'b1);
        check("cs_bad_start", bus.start_o, 1'b0);
        check("cs_bad_busy",  bus.busy, 1'b0);
        check("cs_bad_msg",   bus.msg_o, 8'h05);
        send_frame(8'h4B, 24'h010203, 3);
        send_byte(8'h4B);
        send_byte(8'h09);
        send_byte(8'h09);
        send_byte(8'h09);
        send_byte(8'h00);
        check("cs_bad_key_err", bus.err, 1'b1);
        check_keys("cs_key", 8'h01, 8'h02, 8'h03);
`endif

        repeat (2) @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
